// File: rtl/shuffle_phase_sequencer.sv
// shuffle_phase_sequencer: table-driven opcode scheduler for the R1/R2 shuffle datapath (optional SHUF_SEQ_PERF_EN adds o_stall_cnt)
module shuffle_phase_sequencer #(
  parameter int PROG_LEN = 9,
  parameter int PASS_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [PASS_W-1:0] i_passes,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [1:0]        o_op,
  output logic              o_op_valid,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_prog_we,
  input  logic [3:0]        i_prog_addr,
  input  logic [1:0]        i_prog_data
`ifdef SHUF_SEQ_PERF_EN
  ,
  output logic [15:0]       o_stall_cnt
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  localparam logic [3:0] LAST = 4'(PROG_LEN - 1);
  state_t            r_state;
  logic [3:0]        r_idx;
  logic [PASS_W-1:0] r_pass;
  logic [1:0]        r_op;
  logic              r_op_valid;
  logic              r_in_ready;
  logic              r_done;
  logic [1:0]        r_tab [16];
  logic              w_xfer;
  logic              w_last_slot;
  logic              w_final;
  function automatic logic [1:0] dflt(input int s);
    return (s == 3) ? 2'd2 : (s == 4 || s == 7 || s == 8) ? 2'd3 : (s <= 8) ? 2'd1 : 2'd0;
  endfunction
  assign w_xfer      = (r_state == S_RUN) && r_in_ready && i_in_valid;
  assign w_last_slot = r_idx == LAST;
  assign w_final     = w_xfer && w_last_slot && (r_pass == PASS_W'(1));
  assign o_in_ready  = r_in_ready;
  assign o_op        = r_op;
  assign o_op_valid  = r_op_valid;
  assign o_busy      = r_state == S_RUN;
  assign o_done      = r_done;
  // schedule table: writable only outside RUN and only within PROG_LEN slots
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) r_tab[k] <= dflt(k);
    end else if (i_prog_we && r_state != S_RUN && i_prog_addr <= LAST) begin
      r_tab[i_prog_addr] <= i_prog_data;
    end
  end
  // run control: start handshake, slot/pass tracking and registered opcode issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_pass     <= '0;
      r_op       <= 2'd0;
      r_op_valid <= 1'b0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_op       <= 2'd0;
          r_op_valid <= 1'b0;
          r_done     <= 1'b0;
          if (i_start) begin
            r_idx      <= '0;
            r_pass     <= i_passes;
            r_state    <= (i_passes != '0) ? S_RUN : S_FIN;
            r_in_ready <= i_passes != '0;
            r_done     <= i_passes == '0;
          end
        end
        S_RUN: begin
          r_op       <= w_xfer ? r_tab[r_idx] : 2'd0;
          r_op_valid <= w_xfer;
          if (w_xfer) begin
            r_idx <= w_last_slot ? 4'd0 : r_idx + 4'd1;
            if (w_last_slot) r_pass <= r_pass - PASS_W'(1);
            if (w_final) begin
              r_in_ready <= 1'b0;
              r_state    <= S_FIN;
              r_done     <= 1'b1;
            end
          end
        end
        S_FIN: begin
          r_op       <= 2'd0;
          r_op_valid <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef SHUF_SEQ_PERF_EN
  logic [15:0] r_stall;
  assign o_stall_cnt = r_stall;
  // saturating count of RUN cycles where the sequencer waited on input
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE && i_start)) r_stall <= '0;
    else if (r_state == S_RUN && r_in_ready && !i_in_valid && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end
`endif
endmodule

// File: tb/tb_shuffle_phase_sequencer.sv
// tb_shuffle_phase_sequencer: scoreboard bench for the shuffle phase sequencer
module tb_shuffle_phase_sequencer;
  logic       clk = 0;
  logic       rst = 1;
  logic       i_start = 0;
  logic [7:0] i_passes = 0;
  logic       i_in_valid = 0;
  logic       o_in_ready;
  logic [1:0] o_op;
  logic       o_op_valid;
  logic       o_busy;
  logic       o_done;
  logic       i_prog_we = 0;
  logic [3:0] i_prog_addr = 0;
  logic [1:0] i_prog_data = 0;
`ifdef SHUF_SEQ_PERF_EN
  logic [15:0] o_stall_cnt;
`endif
  int total = 0;
  int bad = 0;
  int m_idx = 0;
  logic [1:0] m_tab [9];
  logic [1:0] sbq [$];
  logic [1:0] exp_op;

  shuffle_phase_sequencer #(.PROG_LEN(9), .PASS_W(8)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_passes(i_passes),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_op(o_op),
    .o_op_valid(o_op_valid), .o_busy(o_busy), .o_done(o_done),
    .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data)
`ifdef SHUF_SEQ_PERF_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // scoreboard: compare the op produced by the last edge, then record this cycle's transfer
  always @(negedge clk) begin
    total++;
    if (o_op_valid) begin
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_op got=%0d want=none", o_op);
      end else begin
        exp_op = sbq.pop_front();
        if (o_op !== exp_op) begin
          bad++;
          $display("FAIL sb_op got=%0d want=%0d", o_op, exp_op);
        end
      end
    end else if (o_op !== 2'd0) begin
      bad++;
      $display("FAIL hold_op got=%0d want=0", o_op);
    end
    if (rst) sbq.delete();
    else if (i_in_valid && o_in_ready) begin
      sbq.push_back(m_tab[m_idx]);
      m_idx = (m_idx == 8) ? 0 : m_idx + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default();
    m_tab = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3};
  endtask

  task automatic start_run(input int p);
    i_start = 1;
    i_passes = 8'(p);
    m_idx = 0;
    tick();
    i_start = 0;
    i_prog_we = 0;
  endtask

  // drives a run; in_valid is low on RUN cycles lo..hi; optional start/prog pokes mid-run
  task automatic drive_run(input int p, input int lo, input int hi, input int poke_start, input int poke_prog,
                           output int n_ops, output int n_done, output int c_done, output int n_busy,
                           output bit coinc);
    int c;
    bit got;
    n_ops = 0; n_done = 0; c_done = -1; n_busy = 0; coinc = 0; got = 0; c = 0;
    start_run(p);
    if (o_busy) n_busy++;
    while (!got && c < 200) begin
      i_in_valid = !(c >= lo && c <= hi);
      if (c == poke_start) begin i_start = 1; i_passes = 8'd5; end
      if (c == poke_prog) begin i_prog_we = 1; i_prog_addr = 4'd1; i_prog_data = 2'd2; end
      tick();
      i_start = 0;
      i_prog_we = 0;
      if (o_busy) n_busy++;
      if (o_op_valid) n_ops++;
      if (o_done) begin n_done++; c_done = c; coinc = o_op_valid; got = 1; end
      c++;
    end
    i_in_valid = 0;
    tick();
    if (o_done) n_done++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    load_default();
    total++;
    if ({o_op, o_op_valid, o_in_ready, o_busy, o_done} !== 6'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000000", {o_op, o_op_valid, o_in_ready, o_busy, o_done});
    end
`ifdef SHUF_SEQ_PERF_EN
    total++;
    if (o_stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", o_stall_cnt); end
`endif
  endtask

  task automatic test_single_pass();
    int n_ops, n_done, c_done, n_busy;
    bit coinc;
    drive_run(1, -1, -1, -1, -1, n_ops, n_done, c_done, n_busy, coinc);
    total++; if (n_ops !== 9) begin bad++; $display("FAIL single_nops got=%0d want=9", n_ops); end
    total++; if (c_done !== 8) begin bad++; $display("FAIL single_done_cycle got=%0d want=8", c_done); end
    total++; if (coinc !== 1'b1) begin bad++; $display("FAIL single_done_coinc got=%0d want=1", coinc); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL single_ndone got=%0d want=1", n_done); end
    total++; if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin bad++; $display("FAIL single_idle got=%b%b want=00", o_busy, o_in_ready); end
  endtask

  task automatic test_two_pass();
    int n_ops, n_done, c_done, n_busy;
    bit coinc;
    drive_run(2, -1, -1, 5, -1, n_ops, n_done, c_done, n_busy, coinc);
    total++; if (n_ops !== 18) begin bad++; $display("FAIL two_nops got=%0d want=18", n_ops); end
    total++; if (n_busy !== 18) begin bad++; $display("FAIL two_busy got=%0d want=18", n_busy); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL two_ndone got=%0d want=1", n_done); end
    total++; if (c_done !== 17) begin bad++; $display("FAIL two_done_cycle got=%0d want=17", c_done); end
  endtask

  task automatic test_stall();
    int n_ops, n_done, c_done, n_busy;
    bit coinc;
    drive_run(1, 3, 5, -1, -1, n_ops, n_done, c_done, n_busy, coinc);
    total++; if (n_ops !== 9) begin bad++; $display("FAIL stall_nops got=%0d want=9", n_ops); end
    total++; if (c_done !== 11) begin bad++; $display("FAIL stall_done_cycle got=%0d want=11", c_done); end
`ifdef SHUF_SEQ_PERF_EN
    total++; if (o_stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt got=%0d want=3", o_stall_cnt); end
`endif
  endtask

  task automatic test_zero_pass();
    i_in_valid = 1;
    start_run(0);
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_in_ready !== 1'b0 || o_op_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_done got=%b%b%b%b want=1000", o_done, o_busy, o_in_ready, o_op_valid);
    end
    tick();
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%0d want=0", o_done); end
    i_in_valid = 0;
    tick();
  endtask

  task automatic test_prog();
    int n_ops, n_done, c_done, n_busy;
    bit coinc;
    i_prog_we = 1; i_prog_addr = 4'd0; i_prog_data = 2'd3;
    m_tab[0] = 2'd3;
    drive_run(1, -1, -1, -1, 2, n_ops, n_done, c_done, n_busy, coinc);
    total++; if (n_ops !== 9) begin bad++; $display("FAIL prog_nops got=%0d want=9", n_ops); end
    drive_run(1, -1, -1, -1, -1, n_ops, n_done, c_done, n_busy, coinc);
    total++; if (n_ops !== 9) begin bad++; $display("FAIL prog_rerun_nops got=%0d want=9", n_ops); end
  endtask

  task automatic test_midrun_reset();
    int n_ops, n_done, c_done, n_busy;
    bit coinc;
    i_in_valid = 1;
    start_run(1);
    for (int c = 0; c < 4; c++) tick();
    rst = 1;
    tick();
    rst = 0;
    i_in_valid = 0;
    load_default();
    total++;
    if ({o_op, o_op_valid, o_in_ready, o_busy, o_done} !== 6'd0) begin
      bad++;
      $display("FAIL midrst_outputs got=%b want=000000", {o_op, o_op_valid, o_in_ready, o_busy, o_done});
    end
    tick();
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%0d want=0", o_done); end
    drive_run(1, -1, -1, -1, -1, n_ops, n_done, c_done, n_busy, coinc);
    total++; if (n_ops !== 9) begin bad++; $display("FAIL midrst_rerun got=%0d want=9", n_ops); end
  endtask

  initial begin
    load_default();
    test_reset();
    test_single_pass();
    test_two_pass();
    test_stall();
    test_zero_pass();
    test_prog();
    test_midrun_reset();
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
